// File: rtl/gpr_wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : regf_w (interface)
//  Purpose  : GPR write-port bundle. One register write per cycle: a
//             destination index and its data. Index 0 is a no-op write.
//  Ports    : regf  - destination register index (ADDR_W)
//             data  - write data (DATA_W)
//  Modports : master - drives regf/data (write-back queue side)
//             slave  - receives regf/data (register file side)
//  Revision : 1.0 - initial release
// ============================================================================
interface regf_w #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] regf;
    logic [DATA_W-1:0] data;

    modport master (output regf, output data);
    modport slave  (input  regf, input  data);
endinterface
`default_nettype wire

// File: rtl/gpr_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_wb_queue
//  Purpose  : Master side of the GPR write port. Merges write-back requests
//             from producer A (in-order pipeline) and producer B (long-latency
//             unit) into a small in-order FIFO, commits one entry per cycle on
//             the rd write port, and offers youngest-match bypass lookups for
//             the rs/rt read addresses.
//  Ports    : clk, rst (async, active low)
//             a_valid/a_regf/a_data/a_ready - producer A request + accept
//             b_valid/b_regf/b_data/b_ready - producer B request + accept
//             rd (regf_w.master)            - GPR write port
//             rs_regf/rs_hit/rs_data        - bypass lookup, rs
//             rt_regf/rt_hit/rt_data        - bypass lookup, rt
//             count                         - occupied entries (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_regf,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_regf,
    input  logic [DATA_W-1:0]      b_data,
    output logic                   b_ready,
    regf_w.master                  rd,
    input  logic [ADDR_W-1:0]      rs_regf,
    output logic                   rs_hit,
    output logic [DATA_W-1:0]      rs_data,
    input  logic [ADDR_W-1:0]      rt_regf,
    output logic                   rt_hit,
    output logic [DATA_W-1:0]      rt_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [ADDR_W-1:0] r_regf [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic              w_a_fire;
    logic              w_b_fire;
    logic              w_a_store;
    logic              w_b_store;
    logic              w_deq;
    logic [PTR_W-1:0]  w_b_slot;

    // Free space ignores the entry leaving this cycle, so readiness never
    // depends on the drain and B's grant only depends on A's grant.
    assign w_free   = c_depth - r_count;
    assign a_ready  = (w_free >= c_one);
    assign b_ready  = (w_free >= (c_one + CNT_W'(a_valid & a_ready)));

    assign w_a_fire = a_valid & a_ready;
    assign w_b_fire = b_valid & b_ready;

    // Writes to register 0 handshake normally but are dropped here.
    assign w_a_store = w_a_fire & (a_regf != '0);
    assign w_b_store = w_b_fire & (b_regf != '0);

    // B lands after A when both are stored in the same cycle.
    assign w_b_slot = r_tail + PTR_W'(w_a_store);

    // The head entry is on the port for the whole cycle and is committed by
    // the register file at the next edge, so every occupied cycle dequeues.
    assign w_deq = (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regf[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_a_store) begin
                r_regf[r_tail] <= a_regf;
                r_data[r_tail] <= a_data;
            end
            if (w_b_store) begin
                r_regf[w_b_slot] <= b_regf;
                r_data[w_b_slot] <= b_data;
            end
            r_tail  <= r_tail + PTR_W'(w_a_store) + PTR_W'(w_b_store);
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_a_store) + CNT_W'(w_b_store)
                       - CNT_W'(w_deq);
        end
    end

    // Write port comes straight from queue registers; an empty queue drives
    // a register-0 no-op write.
    assign rd.regf = w_deq ? r_regf[r_head] : '0;
    assign rd.data = w_deq ? r_data[r_head] : '0;
    assign count   = r_count;

    // Bypass search walks from oldest to youngest; a later match overrides an
    // earlier one so the youngest pending value wins. The head entry being
    // committed this cycle is still included.
    always_comb begin
        rs_hit  = 1'b0;
        rs_data = '0;
        rt_hit  = 1'b0;
        rt_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                if ((rs_regf != '0) && (r_regf[r_head + PTR_W'(k)] == rs_regf)) begin
                    rs_hit  = 1'b1;
                    rs_data = r_data[r_head + PTR_W'(k)];
                end
                if ((rt_regf != '0) && (r_regf[r_head + PTR_W'(k)] == rt_regf)) begin
                    rt_hit  = 1'b1;
                    rt_data = r_data[r_head + PTR_W'(k)];
                end
            end
        end
    end
endmodule
`default_nettype wire
